// File: rtl/rtc_pkg.sv
// Shared constants and mode encoding for the stopwatch counting path.
package rtc_pkg;

    localparam int unsigned COUNT_W          = 24;
    localparam int unsigned TICK_DIV_DEFAULT = 1000000;
    localparam logic [23:0] COUNT_MAX        = 24'hFFFFFF;

    typedef enum logic [1:0] {
        CLEAR = 2'b00,
        RUN   = 2'b01,
        STOP  = 2'b10
    } mode_t;

endpackage

// File: rtl/rtc_prescaler.sv
// 10-ms timebase prescaler. The tick output is a strobe meaning
// "the interval completes on this edge", so the counter can advance
// on the same edge the prescaler wraps.
module rtc_prescaler #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] p;

    assign tick = enable && !clear && (p == P_LAST);

    // Count enabled edges; hold the partial interval while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p <= '0;
        end else if (clear) begin
            p <= '0;
        end else if (enable) begin
            if (p == P_LAST) begin
                p <= '0;
            end else begin
                p <= p + PW'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_count_core.sv
// Stopwatch counting core: 10-ms timebase, elapsed-time counter,
// display latch, sticky overflow and mode register.
// Build option: RTC_COUNT_SATURATE_EN makes the counter saturate at its
// maximum instead of wrapping to zero.
module rtc_count_core
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV = rtc_pkg::TICK_DIV_DEFAULT,
    parameter int unsigned COUNT_W  = rtc_pkg::COUNT_W
) (
    input  logic               i_sclk,
    input  logic               i_reset_n,
    input  logic               i_count_init,
    input  logic               i_count_enb,
    input  logic               i_latch_count,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_count_valid,
    output logic               o_tick,
    output logic               o_overflow
);

    mode_t              mode;
    logic [COUNT_W-1:0] cnt;
    logic               presc_tick;

    rtc_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk     (i_sclk),
        .reset_n (i_reset_n),
        .clear   (i_count_init),
        .enable  (i_count_enb),
        .tick    (presc_tick)
    );

    // Mode register: init over enable over stop; illegal code recovers to CLEAR.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mode <= CLEAR;
        end else begin
            case (mode)
                CLEAR, RUN, STOP: begin
                    if (i_count_init) begin
                        mode <= CLEAR;
                    end else if (i_count_enb) begin
                        mode <= RUN;
                    end else begin
                        mode <= STOP;
                    end
                end
                default: mode <= CLEAR;
            endcase
        end
    end

    // Elapsed-time counter, tick pulse and sticky overflow.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt        <= '0;
            o_tick     <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_count_init) begin
            cnt        <= '0;
            o_tick     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_tick <= presc_tick;
            if (presc_tick) begin
                if (cnt == '1) begin
                    o_overflow <= 1'b1;
`ifdef RTC_COUNT_SATURATE_EN
                    cnt <= cnt;
`else
                    cnt <= '0;
`endif
                end else begin
                    cnt <= cnt + COUNT_W'(1);
                end
            end
        end
    end

    // Display latch: follow the counter while latch is high, freeze otherwise.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_count       <= '0;
            o_count_valid <= 1'b0;
        end else if (i_count_init) begin
            o_count       <= '0;
            o_count_valid <= 1'b0;
        end else if (i_latch_count) begin
            o_count       <= cnt;
            o_count_valid <= (cnt != o_count);
        end else begin
            o_count_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rtc_count_core.sv
// Directed bench for rtc_count_core with a per-cycle reference model
// feeding an expected-value queue.
module tb_rtc_count_core;
    import rtc_pkg::*;

    localparam int unsigned TDIV = 4;
    localparam int unsigned CW   = 24;

    logic          clk;
    logic          i_reset_n;
    logic          i_count_init;
    logic          i_count_enb;
    logic          i_latch_count;
    logic [CW-1:0] o_count;
    logic          o_count_valid;
    logic          o_tick;
    logic          o_overflow;

    rtc_count_core #(
        .TICK_DIV (TDIV),
        .COUNT_W  (CW)
    ) dut (
        .i_sclk        (clk),
        .i_reset_n     (i_reset_n),
        .i_count_init  (i_count_init),
        .i_count_enb   (i_count_enb),
        .i_latch_count (i_latch_count),
        .o_count       (o_count),
        .o_count_valid (o_count_valid),
        .o_tick        (o_tick),
        .o_overflow    (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          tick;
        logic          valid;
        logic          ovf;
        logic [1:0]    mode;
        logic [CW-1:0] oc;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // reference model state
    int unsigned   m_p;
    logic [CW-1:0] m_cnt;
    logic [CW-1:0] m_oc;
    logic          m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        m_p   = 0;
        m_cnt = '0;
        m_oc  = '0;
        m_ovf = 1'b0;
    endtask

    task automatic step(input logic init, input logic enb, input logic latch);
        exp_t e;
        @(negedge clk);
        i_count_init  = init;
        i_count_enb   = enb;
        i_latch_count = latch;
        e = '0;
        if (init) begin
            model_clear();
            e.mode = CLEAR;
        end else begin
            e.mode  = enb ? RUN : STOP;
            e.valid = latch && (m_cnt != m_oc);
            if (latch) m_oc = m_cnt;
            if (enb) begin
                if (m_p == TDIV - 1) begin
                    m_p    = 0;
                    e.tick = 1'b1;
                    if (m_cnt == 24'hFFFFFF) begin
                        m_ovf = 1'b1;
`ifdef RTC_COUNT_SATURATE_EN
                        m_cnt = 24'hFFFFFF;
`else
                        m_cnt = '0;
`endif
                    end else begin
                        m_cnt = m_cnt + 24'd1;
                    end
                end else begin
                    m_p = m_p + 1;
                end
            end
        end
        e.ovf = m_ovf;
        e.oc  = m_oc;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("tick",  {31'd0, o_tick},        {31'd0, e.tick});
        chk("valid", {31'd0, o_count_valid}, {31'd0, e.valid});
        chk("ovf",   {31'd0, o_overflow},    {31'd0, e.ovf});
        chk("mode",  {30'd0, dut.mode},      {30'd0, e.mode});
        chk("count", {8'd0, o_count},        {8'd0, e.oc});
        chk("cnt",   {8'd0, dut.cnt},        {8'd0, e.cnt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks[$];
        int nvalid;
        int ntick;

        i_reset_n     = 1'b0;
        i_count_init  = 1'b0;
        i_count_enb   = 1'b0;
        i_latch_count = 1'b0;
        model_clear();
        #2;
        chk("rst_count", {8'd0, o_count}, 32'd0);
        chk("rst_valid", {31'd0, o_count_valid}, 32'd0);
        chk("rst_tick",  {31'd0, o_tick}, 32'd0);
        chk("rst_ovf",   {31'd0, o_overflow}, 32'd0);
        chk("rst_mode",  {30'd0, dut.mode}, {30'd0, CLEAR});
        @(negedge clk);
        i_reset_n = 1'b1;

        // 1: continuous run with latch following
        step(1'b1, 1'b0, 1'b0);
        nvalid = 0;
        for (int i = 0; i < 21; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (o_tick) ticks.push_back(i + 1);
            if (o_count_valid) nvalid++;
        end
        chk("t1_ntick", ticks.size(), 32'd5);
        for (int k = 0; k < ticks.size() && k < 5; k++)
            chk("t1_tick_edge", ticks[k], 4 * (k + 1));
        chk("t1_nvalid", nvalid, 32'd5);
        chk("t1_count",  {8'd0, o_count}, 32'd5);

        // 2: split - counter runs while the display freezes
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b1);
        chk("t2_count_pre", {8'd0, o_count}, 32'd3);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
        chk("t2_count_held", {8'd0, o_count}, 32'd3);
        chk("t2_cnt_run",    {8'd0, dut.cnt}, 32'd6);
        step(1'b0, 1'b1, 1'b1);
        chk("t2_count_jump", {8'd0, o_count}, 32'd6);
        chk("t2_valid_jump", {31'd0, o_count_valid}, 32'd1);
        step(1'b0, 1'b1, 1'b1);
        chk("t2_valid_once", {31'd0, o_count_valid}, 32'd0);

        // 3: stop keeps the partial interval
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        ntick = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (o_tick) ntick++;
        end
        chk("t3_no_tick_stopped", ntick, 32'd0);
        step(1'b0, 1'b1, 1'b1);
        chk("t3_tick_early", {31'd0, o_tick}, 32'd0);
        step(1'b0, 1'b1, 1'b1);
        chk("t3_tick_resume", {31'd0, o_tick}, 32'd1);

        // 4: init wins over a pending tick
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        chk("t4_p3", {30'd0, dut.u_presc.p}, 32'd3);
        step(1'b1, 1'b1, 1'b1);
        chk("t4_tick",  {31'd0, o_tick}, 32'd0);
        chk("t4_count", {8'd0, o_count}, 32'd0);
        chk("t4_cnt",   {8'd0, dut.cnt}, 32'd0);

        // 5: overflow at counter maximum
        step(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        i_count_init  = 1'b0;
        i_count_enb   = 1'b0;
        i_latch_count = 1'b0;
        force dut.cnt = 24'hFFFFFF;
        #1;
        release dut.cnt;
        m_cnt = 24'hFFFFFF;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        chk("t5_tick", {31'd0, o_tick}, 32'd1);
        chk("t5_ovf",  {31'd0, o_overflow}, 32'd1);
`ifdef RTC_COUNT_SATURATE_EN
        chk("t5_cnt_sat",  {8'd0, dut.cnt}, 32'h00FFFFFF);
`else
        chk("t5_cnt_wrap", {8'd0, dut.cnt}, 32'd0);
`endif
        step(1'b0, 1'b1, 1'b0);
        chk("t5_ovf_sticky", {31'd0, o_overflow}, 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_ovf_cleared", {31'd0, o_overflow}, 32'd0);

        // 6: asynchronous reset mid-interval
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b1);
        chk("t6_cnt7",   {8'd0, dut.cnt}, 32'd7);
        chk("t6_count7", {8'd0, o_count}, 32'd7);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("t6_rst_count", {8'd0, o_count}, 32'd0);
        chk("t6_rst_cnt",   {8'd0, dut.cnt}, 32'd0);
        chk("t6_rst_ovf",   {31'd0, o_overflow}, 32'd0);
        chk("t6_rst_tick",  {31'd0, o_tick}, 32'd0);
        chk("t6_rst_valid", {31'd0, o_count_valid}, 32'd0);
        chk("t6_rst_p",     {30'd0, dut.u_presc.p}, 32'd0);
        model_clear();
        @(negedge clk);
        i_reset_n = 1'b1;
        step(1'b0, 1'b1, 1'b1);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_count_core.md
# rtc_count_core

Counting end of the stopwatch control interface. It consumes the registered `count_init` / `count_enb` / `latch_count` controls from the trigger detection circuit and generates the 10-ms timebase from the system clock. It maintains the 24-bit elapsed-time counter in 10-ms units and holds a latched copy for the display path. While the counter keeps running, that latched copy either follows it (counting) or stays frozen (pause/split).

## Interface
- `TICK_DIV`, default 1000000: system clocks per 10-ms tick (100 MHz clock). Legal range ≥ 2.
- `COUNT_W`, default 24: counter width. Fixed at 24 for this product; it is kept as a parameter only for bench scaling.
- `i_sclk`, in, 1: system clock. All logic is on its rising edge.
- `i_reset_n`, in, 1: reset, asynchronous, active-low.
- `i_count_init`, in, 1: synchronous clear of prescaler, counter, latch and overflow. Highest priority.
- `i_count_enb`, in, 1: prescaler and counter advance while high.
- `i_latch_count`, in, 1: `o_count` tracks the counter while high and holds while low.
- `o_count`, out, COUNT_W: latched elapsed time, in 10-ms units.
- `o_count_valid`, out, 1: one-cycle pulse when `o_count` takes a new value.
- `o_tick`, out, 1: one-cycle pulse, high in the cycle the counter shows its incremented value.
- `o_overflow`, out, 1: sticky flag, set when a tick arrives with the counter at its maximum.

## Operation
- Control inputs come from the same clock domain, already registered. The block adds no synchronizers.
- Mode state register `mode`, with three states: `CLEAR`, `RUN`, `STOP`. Next mode is chosen by priority each cycle:
  - `i_count_init` = 1 → `CLEAR`.
  - otherwise `i_count_enb` = 1 → `RUN`.
  - otherwise → `STOP`.
- `mode` is exported to the bench via hierarchy only. It is not a port.
- In `CLEAR`, on each edge with init high:
  - prescaler, counter, `o_count` and `o_overflow` go to 0.
  - `o_tick` and `o_count_valid` go to 0.
- Prescaler `p` has width clog2(TICK_DIV). On an edge with enb=1 and init=0:
  - if `p` = TICK_DIV-1: `p` ← 0, counter advances, `o_tick` ← 1.
  - otherwise: `p` ← `p`+1, `o_tick` ← 0.
- With enb=0 and init=0, `p` and the counter hold and `o_tick` ← 0. A pause therefore keeps the partial 10-ms interval; it is not discarded.
- Counter advance with the counter at 2^COUNT_W-1: `o_overflow` ← 1 and the behaviour is set per Configuration. Otherwise counter ← counter+1, modulo 2^COUNT_W.
- Latch: on an edge with `i_latch_count`=1 and init=0:
  - `o_count` ← counter (the pre-edge value).
  - `o_count_valid` ← (counter ≠ `o_count`).
- With `i_latch_count`=0, `o_count` holds and `o_count_valid` ← 0.
- Pause, as driven by the trigger circuit (enb=1, latch=0): counting continues and `o_count` stays frozen. Re-asserting latch makes `o_count` jump to the current counter value on the next edge, with `o_count_valid` pulsed.
- Simultaneous init and enb/latch: init wins. Nothing advances that cycle.

## Timing
- Reset (asynchronous assert): `mode`=`CLEAR`, `p`=0, counter=0, `o_count`=0, `o_count_valid`=0, `o_tick`=0, `o_overflow`=0.
- Reset deassertion is taken synchronously. The first edge after release evaluates inputs normally.
- First tick: `o_tick` goes high after exactly TICK_DIV edges with enb=1 following the last init=1 edge. Subsequent ticks follow every TICK_DIV enabled edges.
- Counter-to-`o_count` latency: 1 cycle while latch=1. `o_count_valid` is high in the same cycle as the new `o_count`.
- Reset mid-count clears everything immediately, with no dependence on the clock.

## Configuration
- `RTC_COUNT_SATURATE_EN` defined: at max, the counter stays at 2^COUNT_W-1 and further ticks still pulse `o_tick` but do not change it. `o_overflow` is set on the first such tick.
- Macro not defined: the counter wraps to 0 and `o_overflow` is set on the wrap.
- In both builds, `o_overflow` clears only on reset or init.

## Structure
- Shared package `rtc_pkg` holds:
  - `COUNT_W` = 24.
  - the default `TICK_DIV`.
  - `COUNT_MAX` = 24'hFFFFFF.
  - the mode encoding `CLEAR`=2'b00, `RUN`=2'b01, `STOP`=2'b10.
- One sub-module: `rtc_prescaler`. It has parameter TICK_DIV, inputs clk, reset_n, clear, enable, and a one-cycle tick output. `rtc_count_core` instantiates it and holds the counter, latch, overflow and mode logic.

## Test plan
All tests use TICK_DIV=4 and COUNT_W=24 unless noted.
- Reset then init for 1 cycle, then enb=1 and latch=1 for 20 cycles → `o_tick` at enabled edges 4, 8, 12, 16, 20; counter reaches 5; `o_count` reaches 5 one cycle after the counter; 5 `o_count_valid` pulses.
- Run to counter=3, then latch=0 for 12 cycles with enb=1 → `o_count` holds 3 while the counter reaches 6. Latch=1 → next edge gives `o_count`=6 and a single `o_count_valid` pulse.
- enb=0 after 2 prescaler edges, hold 10 cycles, then enb=1 → next tick after exactly 2 more enabled edges; no tick while stopped.
- init asserted together with enb=1, latch=1 and `p`=3 → no tick; all outputs 0 the next cycle.
- Preload so the counter is 0xFFFFFF (bench force via hierarchy), then one tick:
  - with `RTC_COUNT_SATURATE_EN`: counter stays 0xFFFFFF and `o_overflow`=1.
  - without it: counter becomes 0 and `o_overflow`=1.
  - then init → `o_overflow`=0.
- Drop `i_reset_n` asynchronously mid-interval with counter=7 → all outputs 0 with no clock edge.
